// File: rtl/sort_pkg.sv
// Shared constants and FSM encoding for the rank-sort sequencer.
package sort_pkg;

  localparam int DN              = 25;          // samples per window
  localparam int DW              = 8;           // bits per sample
  localparam int SW              = $clog2(DN);  // bits per rank/index
  localparam int WIN_W           = DW * DN;     // flattened window width
  localparam int SEQ_W           = SW * DN;     // flattened index-vector width
  localparam int TIMEOUT_DEFAULT = 15;          // WAIT cycles before abort

  // One-hot sequencer states.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_LAUNCH  = 6'b000010,
    ST_WAIT    = 6'b000100,
    ST_HOLD    = 6'b001000,
    ST_CAPTURE = 6'b010000,
    ST_ABORT   = 6'b100000
  } state_t;

endpackage

// File: rtl/sort_slot_reg.sv
// Single-entry valid/hold register. Used as the window in-slot and the
// result out-slot of the sort sequencer.
module sort_slot_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);

  // Load has priority over clear so a slot can be drained and refilled on one edge.
  always_ff @(posedge clk) begin
    // NOTE: the data register is reset as well, so every output reads 0 out of reset
    // rather than whatever the flops powered up with.
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments here let the consumer sample the old dout on
      // the same edge that loads the new one.
      full <= 1'b1;
      dout <= din;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/sort_sched.sv
// Sequencer for the 5x5 parallel rank sorter: takes a window, launches one
// sort, captures the sorted index vector and hands window + indices on.
// A watchdog aborts a sort that never finishes and re-syncs the sorter.
module sort_sched
  import sort_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_valid,
  output logic             win_ready,
  input  logic [WIN_W-1:0] win_data,
  output logic             sort_sig,
  output logic [WIN_W-1:0] sort_data,
  output logic             sort_rst_n,
  input  logic             sort_finish,
  input  logic [SEQ_W-1:0] sort_seq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIN_W-1:0] out_data,
  output logic [SEQ_W-1:0] out_seq,
  output logic             sort_err,
  output logic [15:0]      win_cnt
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t                   state;
  logic [WDW-1:0]           wd_cnt;
  logic                     in_full;
  logic                     out_full;
  logic                     out_free;
  logic                     go_capture;
  logic                     go_abort;
  logic                     in_load;
  logic                     in_clear;
  logic                     out_load;
  logic [WIN_W+SEQ_W-1:0]   out_q;

  assign out_free = !out_full;

  // The in-slot is released on the edge that enters CAPTURE or ABORT, so
  // win_ready is already high during those cycles and the next window lands
  // on the same edge the current one moves to the out-slot.
  assign go_capture = ((state == ST_WAIT) && sort_finish && out_free) ||
                      ((state == ST_HOLD) && out_free);
  assign go_abort   = (state == ST_WAIT) && !sort_finish &&
                      (wd_cnt == WDW'(TIMEOUT - 1));

  assign in_load   = win_valid && win_ready;
  assign in_clear  = go_capture || go_abort;
  assign out_load  = (state == ST_CAPTURE);

  assign win_ready = !in_full;
  assign out_valid = out_full;
  assign {out_data, out_seq} = out_q;

  sort_slot_reg #(.W(WIN_W)) u_in_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (in_load),
    .clear (in_clear),
    .din   (win_data),
    .full  (in_full),
    .dout  (sort_data)
  );

  // A new result may load while out_ready drains the old one; out_valid then stays high.
  sort_slot_reg #(.W(WIN_W + SEQ_W)) u_out_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (out_ready),
    .din   ({sort_data, sort_seq}),
    .full  (out_full),
    .dout  (out_q)
  );

  // Sequencer FSM with watchdog, error flag, window counter and sorter control.
  // Every path into LAUNCH passes through IDLE, which is the one idle cycle the
  // sorter needs after a CAPTURE or ABORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wd_cnt     <= '0;
      sort_sig   <= 1'b0;
      sort_rst_n <= 1'b0;
      sort_err   <= 1'b0;
      win_cnt    <= '0;
    end else begin
      sort_sig   <= 1'b0;
      sort_rst_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (in_full) begin
            state    <= ST_LAUNCH;
            sort_sig <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (sort_finish) begin
            // sort_seq is not valid yet; CAPTURE/HOLD sample it a cycle later.
            state <= out_free ? ST_CAPTURE : ST_HOLD;
          end else if (go_abort) begin
            state      <= ST_ABORT;
            sort_rst_n <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (out_free) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          win_cnt <= win_cnt + 1'b1;
          state   <= ST_IDLE;
        end
        ST_ABORT: begin
          sort_err <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
